// File: rtl/riscv_enc_pkg.sv
// Shared RV32I encoder definitions: major opcodes, instruction format
// classes and the opcode-to-format classifier.
package riscv_enc_pkg;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [2:0] {FMT_I, FMT_S, FMT_B, FMT_J, FMT_ILL} fmt_e;

  // Any opcode outside the supported set is classified illegal.
  function automatic fmt_e fmt_of(input logic [6:0] opcode);
    case (opcode)
      OP_IMM, OP_LOAD, OP_JALR: fmt_of = FMT_I;
      OP_STORE:                 fmt_of = FMT_S;
      OP_BRANCH:                fmt_of = FMT_B;
      OP_JAL:                   fmt_of = FMT_J;
      default:                  fmt_of = FMT_ILL;
    endcase
  endfunction

endpackage

// File: rtl/imm_instr_encoder_if.sv
// Request/response bundle of the immediate instruction encoder.
// master = request producer / result consumer, slave = encoder.
interface imm_instr_encoder_if #(parameter int CNT_W = 16);
  logic             in_valid;
  logic             in_ready;
  logic [6:0]       opcode;
  logic [4:0]       rd;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic [31:0]      imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      instr;
  logic             err;
  logic [CNT_W-1:0] enc_count;

  modport master (
    output in_valid, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
    input  in_ready, out_valid, instr, err, enc_count
  );

  modport slave (
    input  in_valid, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
    output in_ready, out_valid, instr, err, enc_count
  );
endinterface

// File: rtl/imm_field_pack.sv
// Combinational packer: scatters register fields and immediate bits into
// the RV32I word layout selected by the format class. Illegal -> all zero.
module imm_field_pack
  import riscv_enc_pkg::*;
(
  input  fmt_e        fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [20:0] imm,
  output logic [31:0] word
);

  // Format-dependent bit placement; bits above each field are dropped.
  always_comb begin
    word = 32'h0;
    case (fmt)
      FMT_I: word = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_J: word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: word = 32'h0;
    endcase
  end

endmodule

// File: rtl/imm_instr_encoder.sv
// Two-stage valid/ready RV32I instruction encoder.
// S1 registers the request, its format class and the immediate range flag;
// S2 assembles and holds the instruction word until the consumer takes it.
// Optional build macro: IMM_RANGE_CHECK_EN (immediate range/alignment faults).
module imm_instr_encoder
  import riscv_enc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic              clk,
  input logic              rst,
  imm_instr_encoder_if.slave bus
);

  logic        s1_valid_reg;
  fmt_e        s1_fmt_reg;
  logic [6:0]  s1_opcode_reg;
  logic [4:0]  s1_rd_reg;
  logic [4:0]  s1_rs1_reg;
  logic [4:0]  s1_rs2_reg;
  logic [2:0]  s1_funct3_reg;
  logic [20:0] s1_imm_reg;
  logic        s1_rng_reg;

  logic        s2_valid_reg;
  logic [31:0] s2_instr_reg;
  logic        s2_err_reg;
  logic [CNT_W-1:0] count_reg;

  fmt_e        in_fmt;
  logic        in_rng;
  logic        in_fire;
  logic        s2_load;
  logic        s1_adv;
  logic [31:0] packed_word;
  logic        unused_in;

  assign in_fmt  = fmt_of(bus.opcode);
  assign s2_load = !s2_valid_reg || bus.out_ready;
  assign s1_adv  = s1_valid_reg && s2_load;
  assign bus.in_ready = !s1_valid_reg || s2_load;
  assign in_fire = bus.in_valid && bus.in_ready;

  // funct7 has no slot in I/S/B/J; upper imm bits matter only to the range check.
  assign unused_in = ^{bus.funct7, bus.imm[31:21]};

`ifdef IMM_RANGE_CHECK_EN
  // Flag immediates that do not sign-fit the field, or odd B/J offsets.
  always_comb begin
    in_rng = 1'b0;
    case (in_fmt)
      FMT_I, FMT_S: in_rng = !((&bus.imm[31:11]) || !(|bus.imm[31:11]));
      FMT_B:        in_rng = !((&bus.imm[31:12]) || !(|bus.imm[31:12])) || bus.imm[0];
      FMT_J:        in_rng = !((&bus.imm[31:20]) || !(|bus.imm[31:20])) || bus.imm[0];
      default:      in_rng = 1'b0;
    endcase
  end
`else
  assign in_rng = 1'b0;
`endif

  // S1: capture the request on an input handshake, drain when S2 takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg  <= 1'b0;
      s1_fmt_reg    <= FMT_ILL;
      s1_opcode_reg <= 7'h0;
      s1_rd_reg     <= 5'h0;
      s1_rs1_reg    <= 5'h0;
      s1_rs2_reg    <= 5'h0;
      s1_funct3_reg <= 3'h0;
      s1_imm_reg    <= 21'h0;
      s1_rng_reg    <= 1'b0;
    end else begin
      if (in_fire) begin
        s1_valid_reg  <= 1'b1;
        s1_fmt_reg    <= in_fmt;
        s1_opcode_reg <= bus.opcode;
        s1_rd_reg     <= bus.rd;
        s1_rs1_reg    <= bus.rs1;
        s1_rs2_reg    <= bus.rs2;
        s1_funct3_reg <= bus.funct3;
        s1_imm_reg    <= bus.imm[20:0];
        s1_rng_reg    <= in_rng;
      end else if (s1_adv) begin
        s1_valid_reg  <= 1'b0;
      end
    end
  end

  imm_field_pack u_pack (
    .fmt    (s1_fmt_reg),
    .opcode (s1_opcode_reg),
    .rd     (s1_rd_reg),
    .rs1    (s1_rs1_reg),
    .rs2    (s1_rs2_reg),
    .funct3 (s1_funct3_reg),
    .imm    (s1_imm_reg),
    .word   (packed_word)
  );

  // S2: load the assembled word whenever the output slot is free or being taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_reg <= 1'b0;
      s2_instr_reg <= 32'h0;
      s2_err_reg   <= 1'b0;
    end else if (s2_load) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_instr_reg <= packed_word;
        s2_err_reg   <= (s1_fmt_reg == FMT_ILL) || s1_rng_reg;
      end
    end
  end

  // Count completed output handshakes, wrapping naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (s2_valid_reg && bus.out_ready) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign bus.out_valid = s2_valid_reg;
  assign bus.instr     = s2_instr_reg;
  assign bus.err       = s2_err_reg;
  assign bus.enc_count = count_reg;

endmodule

// File: tb/tb_imm_instr_encoder.sv
// Self-checking bench for imm_instr_encoder: directed vectors, backpressure,
// async reset mid-stream and a randomized stream against a field-arithmetic model.
module tb_imm_instr_encoder;

  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imm_instr_encoder_if #(.CNT_W(CNT_W)) bus ();
  imm_instr_encoder #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_acc = 0;
  int last_out = 0;
  int acc_count = 0;
  int model_count = 0;
  logic smp_in_ready;
  logic [32:0] exp_q[$];

  logic        r_valid = 1'b0;
  logic        r_ready = 1'b1;
  logic [6:0]  r_op = 7'h0;
  logic [4:0]  r_rd = 5'h0;
  logic [4:0]  r_rs1 = 5'h0;
  logic [4:0]  r_rs2 = 5'h0;
  logic [2:0]  r_f3 = 3'h0;
  logic [6:0]  r_f7 = 7'h0;
  logic [31:0] r_imm = 32'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: place each immediate slice by shift/mask arithmetic.
  function automatic logic [32:0] model(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [2:0] f3, input logic [31:0] imm);
    logic [31:0] w, o, d, a, b, f;
    longint s, lo, hi;
    bit al, ok;
    o = {25'b0, op}; d = {27'b0, rd}; a = {27'b0, rs1}; b = {27'b0, rs2}; f = {29'b0, f3};
    s = longint'($signed(imm));
    ok = 1; al = 0; lo = 0; hi = 0; w = 32'h0;
    case (op)
      7'h13, 7'h03, 7'h67: begin
        w = ((imm & 32'hFFF) << 20) | (a << 15) | (f << 12) | (d << 7) | o;
        lo = -2048; hi = 2047;
      end
      7'h23: begin
        w = (((imm >> 5) & 32'h7F) << 25) | (b << 20) | (a << 15) | (f << 12)
          | ((imm & 32'h1F) << 7) | o;
        lo = -2048; hi = 2047;
      end
      7'h63: begin
        w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (b << 20)
          | (a << 15) | (f << 12) | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7) | o;
        lo = -4096; hi = 4094; al = 1;
      end
      7'h6F: begin
        w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
          | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (d << 7) | o;
        lo = -1048576; hi = 1048574; al = 1;
      end
      default: ok = 0;
    endcase
    if (!ok) return {1'b1, 32'h0};
`ifdef IMM_RANGE_CHECK_EN
    return {((s < lo) || (s > hi) || (al && imm[0])), w};
`else
    return {1'b0, w};
`endif
  endfunction

  // One clock: drive at negedge, sample 1 time unit later, score handshakes.
  task automatic run_cycle();
    logic inf, outf;
    logic [32:0] e;
    @(negedge clk);
    bus.in_valid = r_valid; bus.opcode = r_op; bus.rd = r_rd; bus.rs1 = r_rs1;
    bus.rs2 = r_rs2; bus.funct3 = r_f3; bus.funct7 = r_f7; bus.imm = r_imm;
    bus.out_ready = r_ready;
    #1;
    smp_in_ready = bus.in_ready;
    inf  = bus.in_valid && bus.in_ready;
    outf = bus.out_valid && bus.out_ready;
    check("enc_count", 32'(bus.enc_count), 32'(model_count & 32'hFFFF));
    if (outf) begin
      tests++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_out observed=%h expected=none", bus.instr);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("instr", bus.instr, e[31:0]);
        check("err", {31'b0, bus.err}, {31'b0, e[32]});
        $display("[TB] out cyc=%0d instr=%h err=%0b", cyc, bus.instr, bus.err);
      end
      model_count++;
      last_out = cyc;
    end
    if (inf) begin
      exp_q.push_back(model(r_op, r_rd, r_rs1, r_rs2, r_f3, r_imm));
      last_acc = cyc;
      acc_count++;
      r_valid = 1'b0;
    end
    cyc++;
  endtask

  task automatic set_req(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm);
    r_op = op; r_rd = rd; r_rs1 = rs1; r_rs2 = rs2; r_f3 = f3; r_imm = imm;
    r_f7 = 7'($urandom);
    r_valid = 1'b1;
  endtask

  task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm);
    int n = 0;
    set_req(op, rd, rs1, rs2, f3, imm);
    while (r_valid && n < 100) begin run_cycle(); n++; end
    check("send_timeout", {31'b0, r_valid}, 32'h0);
    r_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    r_valid = 1'b0;
    while (exp_q.size() != 0 && n < 100) begin run_cycle(); n++; end
    check("drain_timeout", exp_q.size(), 32'h0);
  endtask

  logic [6:0] ops [7] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h33};

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.opcode = 7'h0; bus.rd = 5'h0;
    bus.rs1 = 5'h0; bus.rs2 = 5'h0; bus.funct3 = 3'h0; bus.funct7 = 7'h0; bus.imm = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'h0);
    check("rst_instr", bus.instr, 32'h0);
    check("rst_err", {31'b0, bus.err}, 32'h0);
    check("rst_enc_count", 32'(bus.enc_count), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Backpressure: two accepted then stall, all three emerge in order
    r_ready = 1'b0;
    acc_count = 0;
    set_req(7'h13, 5'd5, 5'd6, 5'd0, 3'd0, 32'd100); run_cycle();
    set_req(7'h23, 5'd0, 5'd7, 5'd8, 3'd2, 32'hFFFFFFF0); run_cycle();
    set_req(7'h6F, 5'd3, 5'd0, 5'd0, 3'd0, 32'h0001_2344);
    for (int i = 0; i < 5; i++) begin
      run_cycle();
      check("bp_in_ready", {31'b0, smp_in_ready}, 32'h0);
    end
    check("bp_accepted", acc_count, 32'd2);
    r_ready = 1'b1;
    while (r_valid && acc_count < 4) run_cycle();
    drain();
    check("bp_enc_count", model_count, 32'd3);

    // Directed vectors
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFFFFFF);
    drain();
    check("addi_latency", last_out - last_acc, 32'd2);
    check("addi_word", model(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFFFFFF), {1'b0, 32'hFFF00093});
    send(7'h23, 5'd0, 5'd3, 5'd2, 3'd2, 32'd8);
    send(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFFFFFC);
    send(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048);
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048);
    send(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'd3);
    send(7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 32'd0);
    drain();

    // Randomized stream with random backpressure
    for (int i = 0; i < 300; i++) begin
      if (!r_valid && ($urandom_range(0, 3) != 0)) begin
        logic [31:0] im;
        case ($urandom_range(0, 2))
          0: im = $urandom;
          1: im = 32'($urandom_range(0, 8191)) - 32'd4096;
          default: im = 32'($urandom_range(0, 4194303)) - 32'd2097152;
        endcase
        set_req(ops[$urandom_range(0, 6)], 5'($urandom), 5'($urandom), 5'($urandom),
                3'($urandom), im);
      end
      r_ready = ($urandom_range(0, 3) != 0);
      run_cycle();
    end
    r_ready = 1'b1;
    while (r_valid) run_cycle();
    drain();

    // Async reset with both stages occupied
    r_ready = 1'b0;
    send(7'h03, 5'd9, 5'd10, 5'd0, 3'd2, 32'd44);
    send(7'h67, 5'd0, 5'd1, 5'd0, 3'd0, 32'd0);
    @(negedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_out_valid", {31'b0, bus.out_valid}, 32'h0);
    check("arst_enc_count", 32'(bus.enc_count), 32'h0);
    check("arst_instr", bus.instr, 32'h0);
    exp_q.delete();
    model_count = 0;
    r_valid = 1'b0;
    bus.in_valid = 1'b0;
    r_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run_cycle();
    check("arst_in_ready", {31'b0, smp_in_ready}, 32'h1);
    run_cycle();
    run_cycle();
    send(7'h13, 5'd2, 5'd3, 5'd0, 3'd7, 32'h0000_07FF);
    drain();
    check("arst_latency", last_out - last_acc, 32'd2);
    check("arst_count", model_count, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
